// File: rtl/uart_tx_fifo_arbiter.sv
// uart_tx_fifo_arbiter: round-robin, frame-locked sharing of one TX FIFO write port between two requesters
module uart_tx_fifo_arbiter #(
  parameter int B = 8,
  parameter int MAX_FRAME = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic [B-1:0] req0_data,
  input  logic         req0_last,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [B-1:0] req1_data,
  input  logic         req1_last,
  output logic         req1_ready,
  input  logic         fifo_full,
  output logic         fifo_wr,
  output logic [B-1:0] fifo_w_data,
  output logic [1:0]   grant,
  output logic [7:0]   byte_cnt,
  output logic         forced_rel
);
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_G0   = 2'b01;
  localparam logic [1:0] S_G1   = 2'b10;
  logic [1:0] r_state;
  logic [7:0] r_cnt;
  logic       r_forced;
  logic       r_rr_last;
  logic       w_sel0;
  logic       w_sel1;
  logic       w_xfer;
  logic       w_last;
  logic       w_lim;
  assign w_sel0      = r_state == S_G0;
  assign w_sel1      = r_state == S_G1;
  assign w_xfer      = ((w_sel0 & req0_valid) | (w_sel1 & req1_valid)) & ~fifo_full;
  assign w_last      = w_sel0 ? req0_last : req1_last;
  assign w_lim       = r_cnt == 8'(MAX_FRAME - 1);
  assign fifo_wr     = w_xfer;
  assign req0_ready  = w_xfer & w_sel0;
  assign req1_ready  = w_xfer & w_sel1;
  assign fifo_w_data = w_sel0 ? req0_data : w_sel1 ? req1_data : '0;
  // state encoding doubles as the one-hot grant
  assign grant       = r_state;
  assign byte_cnt    = r_cnt;
  assign forced_rel  = r_forced;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_forced  <= 1'b0;
      r_rr_last <= 1'b1;
    end else begin
      r_forced <= w_xfer & w_lim & ~w_last;
      if (!w_sel0 && !w_sel1)
        r_state <= (req0_valid & (~req1_valid | r_rr_last)) ? S_G0 : req1_valid ? S_G1 : S_IDLE;
      else if (w_xfer & (w_last | w_lim)) begin
        r_state   <= S_IDLE;
        r_rr_last <= w_sel1;
        r_cnt     <= '0;
      end else if (w_xfer)
        r_cnt <= r_cnt + 8'd1;
    end
  end
endmodule
